// File: rtl/eaglesong_sponge_ctrl.sv
// Eaglesong sponge controller: packs message bytes into 32-byte blocks, pads,
// drives an external permutation core and presents the 256-bit digest.
module eaglesong_sponge_ctrl #(
  parameter logic [7:0]  DELIMITER    = 8'h06,
  parameter logic [15:0] PERM_TIMEOUT = 16'd1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        msg_byte,
  input  logic              msg_valid,
  input  logic              msg_last,
  input  logic              msg_empty,
  output logic              msg_ready,
  output logic [15:0][31:0] perm_state_in,
  output logic              perm_start,
  input  logic [15:0][31:0] perm_state_out,
  input  logic              perm_done,
  output logic [255:0]      digest,
  output logic              digest_valid,
  input  logic              digest_ack,
  output logic              error
);

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned RATE_WORDS = 8;
  localparam int unsigned N_WORDS    = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned WAIT_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_START,
    S_WAIT,
    S_DONE
  } fsm_e;

  fsm_e                                fsm_q, fsm_d;
  logic [N_WORDS-1:0][WORD_W-1:0]      state_q, state_d;
  logic [RATE_WORDS-1:0][WORD_W-1:0]   blk_q, blk_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic                                final_q, final_d;
  logic                                pad_q, pad_d;
  logic [WAIT_W-1:0]                   wait_q, wait_d;
  logic                                ready_q, ready_d;
  logic                                start_q, start_d;
  logic [N_WORDS-1:0][WORD_W-1:0]      pin_q, pin_d;
  logic [255:0]                        digest_q, digest_d;
  logic                                dvalid_q, dvalid_d;
  logic                                error_q, error_d;

  logic                                accept;
  logic                                clr;
  logic [2:0]                          idx;
  logic [WORD_W-1:0]                   word_v;
  logic [RATE_WORDS-1:0][WORD_W-1:0]   pad_blk;

  assign pad_blk = {{(RATE_WORDS-1){32'h0}}, {24'h0, DELIMITER}};

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q    <= S_IDLE;
      state_q  <= '0;
      blk_q    <= '0;
      cnt_q    <= '0;
      final_q  <= 1'b0;
      pad_q    <= 1'b0;
      wait_q   <= '0;
      ready_q  <= 1'b0;
      start_q  <= 1'b0;
      pin_q    <= '0;
      digest_q <= '0;
      dvalid_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      blk_q    <= blk_d;
      cnt_q    <= cnt_d;
      final_q  <= final_d;
      pad_q    <= pad_d;
      wait_q   <= wait_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      pin_q    <= pin_d;
      digest_q <= digest_d;
      dvalid_q <= dvalid_d;
      error_q  <= error_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they are
  // valid in the same cycle the FSM occupies the corresponding state.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    final_d = final_q;
    pad_d   = pad_q;
    wait_d  = wait_q;
    error_d = error_q;
    clr     = 1'b0;
    accept  = msg_valid & ready_q;
    idx     = cnt_q[4:2];
    word_v  = '0;

    unique case (fsm_q)
      S_IDLE, S_COLLECT: begin
        if (accept) begin
          // Delimiter follows the last byte in the same word unless that word is full
          word_v = {blk_q[idx][23:0], msg_byte};
          if (msg_last && (cnt_q[1:0] != 2'd3)) begin
            word_v = {word_v[23:0], DELIMITER};
          end
          blk_d[idx] = word_v;
          if (msg_last && (cnt_q[1:0] == 2'd3) && (cnt_q != 5'd31)) begin
            blk_d[idx + 3'd1] = {24'h0, DELIMITER};
          end
          cnt_d = cnt_q + 5'd1;
          if (msg_last) begin
            final_d = 1'b1;
            pad_d   = (cnt_q == 5'd31);
            fsm_d   = S_START;
          end else if (cnt_q == 5'd31) begin
            fsm_d = S_START;
          end else begin
            fsm_d = S_COLLECT;
          end
        end else if ((fsm_q == S_IDLE) && ready_q && msg_empty) begin
          blk_d   = pad_blk;
          final_d = 1'b1;
          pad_d   = 1'b0;
          fsm_d   = S_START;
        end
      end
      S_START: begin
        wait_d = '0;
        cnt_d  = '0;
        fsm_d  = S_WAIT;
      end
      S_WAIT: begin
        if ((wait_q >= 16'd2) && perm_done) begin
          state_d = perm_state_out;
          blk_d   = '0;
          if (pad_q) begin
            blk_d = pad_blk;
            pad_d = 1'b0;
            fsm_d = S_START;
          end else if (final_q) begin
            fsm_d = S_DONE;
          end else begin
            fsm_d = S_COLLECT;
          end
        end else if (wait_q == (PERM_TIMEOUT - 16'd1)) begin
          error_d = 1'b1;
          clr     = 1'b1;
          fsm_d   = S_IDLE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_DONE: begin
        if (digest_ack) begin
          clr   = 1'b1;
          fsm_d = S_IDLE;
        end
      end
      default: begin
        clr   = 1'b1;
        fsm_d = S_IDLE;
      end
    endcase

    if (clr) begin
      state_d = '0;
      blk_d   = '0;
      cnt_d   = '0;
      final_d = 1'b0;
      pad_d   = 1'b0;
    end

    ready_d  = (fsm_d == S_IDLE) || (fsm_d == S_COLLECT);
    start_d  = (fsm_d == S_START);
    dvalid_d = (fsm_d == S_DONE);

    pin_d = pin_q;
    if (fsm_d == S_START) begin
      for (int i = 0; i < RATE_WORDS; i++) pin_d[i] = state_d[i] ^ blk_d[i];
      for (int i = RATE_WORDS; i < N_WORDS; i++) pin_d[i] = state_d[i];
    end

    digest_d = digest_q;
    if (fsm_d == S_DONE) begin
      for (int i = 0; i < RATE_WORDS; i++) digest_d[(RATE_WORDS-1-i)*WORD_W +: WORD_W] = state_d[i];
    end
  end

  assign msg_ready     = ready_q;
  assign perm_start    = start_q;
  assign perm_state_in = pin_q;
  assign digest        = digest_q;
  assign digest_valid  = dvalid_q;
  assign error         = error_q;

endmodule
